// File: rtl/dec_pkg.sv
// Shared widths and types for the 6-to-64 one-hot decoder.
// Index width, output width and predecode group width live here.
package dec_pkg;
    localparam int IDX_W = 6;
    localparam int OUT_W = 64;
    localparam int GRP_W = 8;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [OUT_W-1:0] onehot_t;
endpackage

// File: rtl/dec_8b.sv
// 3-to-8 one-hot predecoder with enable; purely combinational.
module dec_8b
    import dec_pkg::*;
(
    input  logic             i_en,
    input  logic [2:0]       i_sel,
    output logic [GRP_W-1:0] o_dec
);
    always_comb begin
        o_dec = '0;
        if (i_en) begin
            o_dec[i_sel] = 1'b1;
        end
    end
endmodule

// File: rtl/dec_64b_sync.sv
// 6-bit index to 64-bit one-hot decoder built from two 3-to-8 predecodes
// and an 8x8 AND matrix, with an optional output register stage.
module dec_64b_sync
    import dec_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  idx_t    in_data_i,
    input  logic    in_valid_i,
    output onehot_t out_data_o,
    output logic    out_valid_o
);
    logic [GRP_W-1:0] w_hi;
    logic [GRP_W-1:0] w_lo;
    onehot_t          w_dec;

    // Valid gates only the upper predecode, which is enough to zero every AND.
    dec_8b u_dec_hi (
        .i_en  (in_valid_i),
        .i_sel (in_data_i[5:3]),
        .o_dec (w_hi)
    );

    dec_8b u_dec_lo (
        .i_en  (1'b1),
        .i_sel (in_data_i[2:0]),
        .o_dec (w_lo)
    );

    for (genvar h = 0; h < GRP_W; h++) begin : g_hi
        for (genvar l = 0; l < GRP_W; l++) begin : g_lo
            assign w_dec[GRP_W*h + l] = w_hi[h] & w_lo[l];
        end
    end

    if (REG_OUT) begin : g_reg
        onehot_t r_data;
        logic    r_valid;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_data  <= w_dec;
                r_valid <= in_valid_i;
            end
        end

        assign out_data_o  = r_data;
        assign out_valid_o = r_valid;
    end else begin : g_comb
        // Forcing zero during reset keeps both builds observably identical.
        assign out_data_o  = rst_i ? '0 : w_dec;
        assign out_valid_o = rst_i ? 1'b0 : in_valid_i;
    end
endmodule

// File: tb/tb_dec_64b_sync.sv
// Directed bench for dec_64b_sync: registered and combinational builds side by side.
module tb_dec_64b_sync;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  in_data;
    logic        in_valid;
    logic [63:0] q1_data;
    logic        q1_valid;
    logic [63:0] q0_data;
    logic        q0_valid;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dec_64b_sync #(.REG_OUT(1'b1)) u_dut_reg (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .out_data_o  (q1_data),
        .out_valid_o (q1_valid)
    );

    dec_64b_sync #(.REG_OUT(1'b0)) u_dut_comb (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .out_data_o  (q0_data),
        .out_valid_o (q0_valid)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  bidx [4] = '{6'd7, 6'd8, 6'd55, 6'd56};
    logic [63:0] bexp [4] = '{64'h0000_0000_0000_0080, 64'h0000_0000_0000_0100,
                              64'h0080_0000_0000_0000, 64'h0100_0000_0000_0000};

    initial begin
        logic [63:0] e;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 6'd0;
        tick();
        check("reset_reg_data", q1_data, 64'h0);
        check("reset_reg_valid", {63'h0, q1_valid}, 64'h0);
        in_valid = 1'b1;
        in_data  = 6'd5;
        #1;
        check("reset_comb_data", q0_data, 64'h0);
        check("reset_comb_valid", {63'h0, q0_valid}, 64'h0);
        tick();
        check("reset_wins_reg", q1_data, 64'h0);

        // Full sweep 0..63
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_data  = 6'(i);
            in_valid = 1'b1;
            e = 64'h1 << i;
            #1;
            check($sformatf("sweep_comb_%0d", i), q0_data, e);
            tick();
            check($sformatf("sweep_reg_%0d", i), q1_data, e);
            check($sformatf("sweep_reg_vld_%0d", i), {63'h0, q1_valid}, 64'h1);
            check($sformatf("sweep_ones_%0d", i), 64'($countones(q1_data)), 64'h1);
        end

        // Invalid input
        in_valid = 1'b0;
        in_data  = 6'd37;
        #1;
        check("inv_comb_data", q0_data, 64'h0);
        check("inv_comb_valid", {63'h0, q0_valid}, 64'h0);
        tick();
        check("inv_reg_data", q1_data, 64'h0);
        check("inv_reg_valid", {63'h0, q1_valid}, 64'h0);

        // Combinational build same-cycle behaviour
        in_valid = 1'b1;
        in_data  = 6'd9;
        #1;
        check("comb_9_data", q0_data, 64'h200);
        check("comb_9_valid", {63'h0, q0_valid}, 64'h1);
        in_valid = 1'b0;
        #1;
        check("comb_drop_data", q0_data, 64'h0);
        check("comb_drop_valid", {63'h0, q0_valid}, 64'h0);

        // Reset on a valid edge, then resume
        tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'd12;
        tick();
        check("rst12_reg_data", q1_data, 64'h0);
        check("rst12_reg_valid", {63'h0, q1_valid}, 64'h0);
        rst     = 1'b0;
        in_data = 6'd13;
        tick();
        check("post_rst13_data", q1_data, 64'h2000);
        check("post_rst13_valid", {63'h0, q1_valid}, 64'h1);

        // Mid-stream reset discards in-flight decode
        in_data = 6'd20;
        tick();
        check("stream20", q1_data, 64'h0010_0000);
        rst     = 1'b1;
        in_data = 6'd21;
        tick();
        check("mid_rst_data", q1_data, 64'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("no_replay_data", q1_data, 64'h0);
        check("no_replay_valid", {63'h0, q1_valid}, 64'h0);

        // Predecode group boundaries
        in_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            in_data = bidx[b];
            #1;
            check($sformatf("bound_comb_%0d", bidx[b]), q0_data, bexp[b]);
            tick();
            check($sformatf("bound_reg_%0d", bidx[b]), q1_data, bexp[b]);
            check($sformatf("bound_ones_%0d", bidx[b]), 64'($countones(q1_data)), 64'h1);
        end

        // Back-to-back toggling between the two extremes
        for (int t = 0; t < 8; t++) begin
            in_data = (t % 2 == 0) ? 6'd0 : 6'd63;
            tick();
            check($sformatf("toggle_%0d", t), q1_data,
                  (t % 2 == 0) ? 64'h0000_0000_0000_0001 : 64'h8000_0000_0000_0000);
            check($sformatf("toggle_ones_%0d", t), 64'($countones(q1_data)), 64'h1);
        end

        // Valid to invalid clears data at the same offset
        in_valid = 1'b0;
        tick();
        check("fall_data", q1_data, 64'h0);
        check("fall_valid", {63'h0, q1_valid}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
